// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: single-outstanding imem requests, small instruction buffer, redirect/kill
module if_stage #(
    parameter int                    PC_WIDTH   = 64,
    parameter logic [PC_WIDTH-1:0]   RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic                if_valid,
    output logic [31:0]         if_inst,
    output logic [PC_WIDTH-1:0] if_pc,
    input  logic                id_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_KILL = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   fetch_pc;
    logic [PC_WIDTH-1:0]   inflight_pc;
    logic [CW-1:0]         fifo_count;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [31:0]           inst_mem [FIFO_DEPTH];
    logic [PC_WIDTH-1:0]   pc_mem   [FIFO_DEPTH];

    logic                  outstanding;
    logic [CW:0]           occupancy;
    logic                  credit;
    logic                  grant;
    logic                  push;
    logic                  pop;
    logic                  unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // A request in flight reserves a buffer slot so a returning response always fits.
    assign outstanding = (state_q != S_REQ);
    assign occupancy   = {1'b0, fifo_count} + {{CW{1'b0}}, outstanding};
    assign credit      = (occupancy < (CW + 1)'(FIFO_DEPTH));

    assign imem_req  = (state_q == S_REQ) & credit & ~redirect_valid & ~rst;
    assign imem_addr = {fetch_pc[PC_WIDTH-1:2], 2'b00};
    assign grant     = imem_req & imem_gnt;

    assign push = (state_q == S_WAIT) & imem_rvalid & ~redirect_valid & ~rst;

    assign if_valid = (fifo_count != '0) & ~redirect_valid & ~rst;
    assign if_inst  = if_valid ? inst_mem[rd_ptr] : 32'd0;
    assign if_pc    = if_valid ? pc_mem[rd_ptr]   : '0;
    assign pop      = if_valid & id_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ: begin
                if (grant) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end else if (redirect_valid) begin
                    state_d = S_KILL;
                end
            end
            S_KILL: begin
                // The killed response is still owed by memory; only its arrival frees us.
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                inflight_pc <= fetch_pc;
            end
            if (redirect_valid) begin
                fetch_pc   <= {redirect_pc[PC_WIDTH-1:2], 2'b00};
                fifo_count <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + PC_WIDTH'(4);
                end
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                if (push && !pop) begin
                    fifo_count <= fifo_count + CW'(1);
                end else if (pop && !push) begin
                    fifo_count <= fifo_count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= inflight_pc;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [63:0] if_pc;
    logic        id_ready;

    int total = 0;
    int bad   = 0;

    int          mem_lat  = 1;
    int          wait_cnt = 0;
    logic [63:0] pend_addr = '0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_inst        (if_inst),
        .if_pc          (if_pc),
        .id_ready       (id_ready)
    );

    typedef struct {
        logic        rdy;
        logic        req;
        logic [63:0] addr;
        logic        valid;
        logic [63:0] pc;
    } vec_t;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string name, input logic req, input logic [63:0] addr,
                              input logic valid, input logic [63:0] pc);
        chk({name, ".req"}, {63'd0, imem_req}, {63'd0, req});
        if (req) chk({name, ".addr"}, imem_addr, addr);
        chk({name, ".valid"}, {63'd0, if_valid}, {63'd0, valid});
        if (valid) begin
            chk({name, ".pc"}, if_pc, pc);
            chk({name, ".inst"}, {32'd0, if_inst}, {32'd0, mem_word(pc)});
        end else begin
            chk({name, ".pc0"}, if_pc, 64'd0);
            chk({name, ".inst0"}, {32'd0, if_inst}, 64'd0);
        end
    endtask

    // Memory model: grants sampled before the edge, response mem_lat cycles after the grant.
    task automatic tick();
        logic        granted;
        logic [63:0] ga;
        granted = imem_req & imem_gnt;
        ga      = imem_addr;
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (rst) begin
            wait_cnt = 0;
        end else begin
            if (granted) begin
                wait_cnt  = mem_lat;
                pend_addr = ga;
            end
            if (wait_cnt > 0) begin
                wait_cnt--;
                if (wait_cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(pend_addr);
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_rvalid = 1'b0;
        wait_cnt = 0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    vec_t vecs[21];

    initial begin
        rst            = 1'b1;
        imem_gnt       = 1'b1;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;

        vecs[0]  = '{1'b1, 1'b1, 64'h8000_0000, 1'b0, 64'h0};
        vecs[1]  = '{1'b1, 1'b0, 64'h0,         1'b0, 64'h0};
        vecs[2]  = '{1'b1, 1'b1, 64'h8000_0004, 1'b1, 64'h8000_0000};
        vecs[3]  = '{1'b1, 1'b0, 64'h0,         1'b0, 64'h0};
        vecs[4]  = '{1'b1, 1'b1, 64'h8000_0008, 1'b1, 64'h8000_0004};
        vecs[5]  = '{1'b1, 1'b0, 64'h0,         1'b0, 64'h0};
        vecs[6]  = '{1'b1, 1'b1, 64'h8000_000C, 1'b1, 64'h8000_0008};
        vecs[7]  = '{1'b0, 1'b0, 64'h0,         1'b0, 64'h0};
        vecs[8]  = '{1'b0, 1'b1, 64'h8000_0010, 1'b1, 64'h8000_000C};
        for (int i = 9; i <= 16; i++) vecs[i] = '{1'b0, 1'b0, 64'h0, 1'b1, 64'h8000_000C};
        vecs[17] = '{1'b1, 1'b0, 64'h0,         1'b1, 64'h8000_000C};
        vecs[18] = '{1'b1, 1'b1, 64'h8000_0014, 1'b1, 64'h8000_0010};
        vecs[19] = '{1'b1, 1'b0, 64'h0,         1'b0, 64'h0};
        vecs[20] = '{1'b1, 1'b1, 64'h8000_0018, 1'b1, 64'h8000_0014};

        // Reset state, then streaming with a 1-cycle memory and a 10-cycle decode stall
        tick();
        expect_out("reset", 1'b0, 64'h0, 1'b0, 64'h0);
        do_reset();
        for (int i = 0; i < 21; i++) begin
            id_ready = vecs[i].rdy;
            #1;
            expect_out($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].valid, vecs[i].pc);
            tick();
        end

        // Redirect while waiting on a 3-cycle response
        do_reset();
        mem_lat = 3;
        id_ready = 1'b1;
        #1;
        expect_out("kill.c0", 1'b1, 64'h8000_0000, 1'b0, 64'h0);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0103;
        #1;
        expect_out("kill.redir", 1'b0, 64'h0, 1'b0, 64'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        expect_out("kill.c2", 1'b0, 64'h0, 1'b0, 64'h0);
        tick();
        chk("kill.stale_rvalid", {63'd0, imem_rvalid}, 64'd1);
        expect_out("kill.c3", 1'b0, 64'h0, 1'b0, 64'h0);
        tick();
        mem_lat = 1;
        expect_out("kill.c4", 1'b1, 64'h8000_0100, 1'b0, 64'h0);
        tick();
        expect_out("kill.c5", 1'b0, 64'h0, 1'b0, 64'h0);
        tick();
        id_ready = 1'b0;
        #1;
        expect_out("kill.c6", 1'b1, 64'h8000_0104, 1'b1, 64'h8000_0100);
        tick();

        // Redirect coinciding with rvalid while one entry is buffered
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0200;
        #1;
        chk("flush.rvalid", {63'd0, imem_rvalid}, 64'd1);
        expect_out("flush.redir", 1'b0, 64'h0, 1'b0, 64'h0);
        tick();
        redirect_valid = 1'b0;
        imem_gnt = 1'b0;
        id_ready = 1'b1;
        #1;
        expect_out("flush.after", 1'b1, 64'h8000_0200, 1'b0, 64'h0);

        // Grant withheld for 5 cycles
        for (int i = 0; i < 5; i++) begin
            expect_out($sformatf("nognt%0d", i), 1'b1, 64'h8000_0200, 1'b0, 64'h0);
            tick();
        end
        imem_gnt = 1'b1;
        #1;
        expect_out("gnt", 1'b1, 64'h8000_0200, 1'b0, 64'h0);
        tick();
        expect_out("gnt.wait", 1'b0, 64'h0, 1'b0, 64'h0);
        tick();
        expect_out("gnt.deliver", 1'b1, 64'h8000_0204, 1'b1, 64'h8000_0200);
        tick();

        // Reset mid-WAIT, then redirect to the top of the address space
        rst = 1'b1;
        imem_rvalid = 1'b0;
        wait_cnt = 0;
        #1;
        expect_out("rst.mid", 1'b0, 64'h0, 1'b0, 64'h0);
        tick();
        rst = 1'b0;
        #1;
        expect_out("rst.restart", 1'b1, 64'h8000_0000, 1'b0, 64'h0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        expect_out("wrap.redir", 1'b0, 64'h0, 1'b0, 64'h0);
        tick();
        redirect_valid = 1'b0;
        #1;
        expect_out("wrap.top", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0);
        tick();
        expect_out("wrap.wait", 1'b0, 64'h0, 1'b0, 64'h0);
        tick();
        expect_out("wrap.zero", 1'b1, 64'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
